// File: rtl/seq_gen_pkg.sv
// Shared types and default widths for the seq_gen run/gap pattern generator.
package seq_gen_pkg;

    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between a controller (master) and seq_gen (slave).
interface seq_gen_if import seq_gen_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] gap_len;
    logic             x;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] run_cnt;

    modport master (
        output req_valid, run_len, gap_len,
        input  req_ready, x, busy, done, run_cnt
    );

    modport slave (
        input  req_valid, run_len, gap_len,
        output req_ready, x, busy, done, run_cnt
    );

endinterface

// File: rtl/seq_gen_len_cnt.sv
// Loadable down-counter shared by the RUN and GAP phases; holds at zero.
module len_cnt import seq_gen_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LEN_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - LEN_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_gen.sv
// Run/gap serial pattern generator: run_len ones then max(gap_len,1) zeros per request.
// Optional macro SEQ_GEN_REPEAT_EN adds rep_en to loop on the latched lengths.
module seq_gen import seq_gen_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic      clk,
    input  logic      reset,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic      rep_en,
`endif
    seq_gen_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [LEN_W-1:0] run_len_reg;
    logic [LEN_W-1:0] gap_len_reg;
    logic [CNT_W-1:0] run_cnt_reg;
    logic             handshake;
    logic             repeat_go;
    logic             cnt_load;
    logic [LEN_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // The counter holds "cycles remaining after this one", so zero marks the last cycle
    // of a phase; a zero gap still yields one GAP cycle.
    function automatic logic [LEN_W-1:0] gap_load(input logic [LEN_W-1:0] g);
        return (g == '0) ? '0 : g - LEN_W'(1);
    endfunction

`ifdef SEQ_GEN_REPEAT_EN
    assign repeat_go = rep_en;
`else
    assign repeat_go = 1'b0;
`endif

    assign handshake = bus.req_valid && (state_reg == S_IDLE);

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state_reg)
            S_IDLE: begin
                if (handshake) begin
                    cnt_load = 1'b1;
                    if (bus.run_len != '0) begin
                        state_next = S_RUN;
                        cnt_val    = bus.run_len - LEN_W'(1);
                    end else begin
                        state_next = S_GAP;
                        cnt_val    = gap_load(bus.gap_len);
                    end
                end
            end
            S_RUN: begin
                if (cnt_zero) begin
                    state_next = S_GAP;
                    cnt_load   = 1'b1;
                    cnt_val    = gap_load(gap_len_reg);
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    if (repeat_go) begin
                        cnt_load = 1'b1;
                        if (run_len_reg != '0) begin
                            state_next = S_RUN;
                            cnt_val    = run_len_reg - LEN_W'(1);
                        end else begin
                            state_next = S_GAP;
                            cnt_val    = gap_load(gap_len_reg);
                        end
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cnt_dec = (state_reg != S_IDLE) && !cnt_zero;

    len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            run_len_reg <= '0;
            gap_len_reg <= '0;
            run_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                run_len_reg <= bus.run_len;
                gap_len_reg <= bus.gap_len;
            end
            if ((state_reg == S_RUN) && cnt_zero) begin
                run_cnt_reg <= run_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Every output decodes registered state only.
    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.x         = (state_reg == S_RUN);
    assign bus.done      = (state_reg == S_GAP) && cnt_zero;
    assign bus.run_cnt   = run_cnt_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: per-cycle expectations queued at request time, checked each negedge.
// Build with SEQ_GEN_REPEAT_EN defined to exercise the repeat scenario.
module tb_seq_gen;

    logic clk = 1'b0;
    logic reset;
`ifdef SEQ_GEN_REPEAT_EN
    logic rep_en = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_gen_if #(.LEN_W(4), .CNT_W(8)) bus ();

    seq_gen #(.LEN_W(4), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef SEQ_GEN_REPEAT_EN
        .rep_en (rep_en),
`endif
        .bus    (bus)
    );

    typedef struct {
        logic       x;
        logic       done;
        logic       busy;
        logic       ready;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt  = 8'd0;
    int         y_cnt    = 0;
    logic       x_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic x, input logic done, input logic busy,
                        input logic ready, input logic [7:0] cnt);
        exp_t e;
        e.x = x; e.done = done; e.busy = busy; e.ready = ready; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Expected trace for one accepted request, starting the cycle after the handshake edge.
    task automatic push_req(input int r, input int g);
        int n;
        for (int i = 0; i < r; i++) push(1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        if (r != 0) exp_cnt++;
        n = (g == 0) ? 1 : g;
        for (int i = 0; i < n; i++) push(1'b0, (i == n - 1), 1'b1, 1'b0, exp_cnt);
        push(1'b0, 1'b0, 1'b0, 1'b1, exp_cnt);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // skip_arm: req_valid already high from the previous request, so this edge is the handshake.
    task automatic do_req(input logic [3:0] r, input logic [3:0] g, input bit keep, input bit skip_arm);
        if (!skip_arm) begin
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b1;
        bus.run_len   = r;
        bus.gap_len   = g;
        if (!skip_arm) @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
        push_req(int'(r), int'(g));
        $display("req run_len=%0d gap_len=%0d expect run_cnt=%0d", r, g, exp_cnt);
        drain();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.x && !x_prev) y_cnt++;
        x_prev = bus.x;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("x",         bus.x,         e.x);
            check("done",      bus.done,      e.done);
            check("busy",      bus.busy,      e.busy);
            check("req_ready", bus.req_ready, e.ready);
            check("run_cnt",   bus.run_cnt,   e.cnt);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int y0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.run_len   = '0;
        bus.gap_len   = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        $display("reset state");
        drain();
        #1 reset = 1'b0;

        // Basic patterns including zero-length run/gap and the maximum run
        do_req(4'd3, 4'd2, 1'b0, 1'b0);
        do_req(4'd0, 4'd0, 1'b0, 1'b0);
        do_req(4'd15, 4'd0, 1'b0, 1'b0);
        do_req(4'd2, 4'd3, 1'b0, 1'b0);
        do_req(4'd0, 4'd4, 1'b0, 1'b0);

        // req_valid held high: 1,0,idle per request, one detector pulse per run
        y0 = y_cnt;
        do_req(4'd1, 4'd1, 1'b1, 1'b0);
        do_req(4'd1, 4'd1, 1'b1, 1'b1);
        do_req(4'd1, 4'd1, 1'b0, 1'b1);
        check("y_pulses", y_cnt - y0, 3);

        // Reset on the 2nd RUN cycle of a run_len=5 request
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.run_len = 4'd5; bus.gap_len = 4'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        push(1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        $display("req run_len=5 gap_len=2 with reset on 2nd run cycle");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 8'd0;
        drain();

        // A request coinciding with reset is dropped
        @(posedge clk); #1;
        reset = 1'b1; bus.req_valid = 1'b1; bus.run_len = 4'd3; bus.gap_len = 4'd1;
        @(posedge clk); #1;
        reset = 1'b0; bus.req_valid = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        $display("req run_len=3 during reset (dropped)");
        drain();

        // 256 single-cycle runs wrap the counter back to 0
        for (int i = 0; i < 256; i++) do_req(4'd1, 4'd0, 1'b0, 1'b0);
        #1;
        check("run_cnt_wrap", bus.run_cnt, 0);

`ifdef SEQ_GEN_REPEAT_EN
        // Repeat: 1,1,0 per period with done each period; stop after the 3rd period
        @(posedge clk); #1;
        rep_en = 1'b1;
        bus.req_valid = 1'b1; bus.run_len = 4'd2; bus.gap_len = 4'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push(1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
            push(1'b1, 1'b0, 1'b1, 1'b0, exp_cnt);
            exp_cnt++;
            push(1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, exp_cnt);
        $display("req run_len=2 gap_len=1 repeating 3 periods");
        repeat (6) @(posedge clk);
        #1 rep_en = 1'b0;
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: LEN_W, default 4, width of the run and gap length fields.
REQ-002 Parameter: CNT_W, default 8, width of the completed-run counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  request strobe from the controller.
REQ-006 Port: req_ready  output  1  block can accept a request.
REQ-007 Port: run_len  input  LEN_W  number of x=1 cycles; sampled on handshake.
REQ-008 Port: gap_len  input  LEN_W  number of x=0 cycles after the run; sampled on handshake.
REQ-009 Port: x  output  1  serial stream to the run-start detector.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle pulse on the last gap cycle of a request.
REQ-012 Port: run_cnt  output  CNT_W  count of completed non-empty runs; wraps modulo 2^CNT_W.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and GAP.
REQ-014 req_ready SHALL be high only in IDLE.
REQ-015 The handshake SHALL be req_valid & req_ready. req_valid while busy SHALL be ignored without being queued.
REQ-016 On handshake at edge N, the FSM SHALL latch run_len and gap_len, and x SHALL be 1 from the cycle after edge N.
- Transition: IDLE→RUN, or IDLE→GAP if run_len==0.
REQ-017 In RUN, x SHALL be 1 for exactly run_len cycles, then the FSM SHALL enter GAP.
REQ-018 In GAP, x SHALL be 0 for max(gap_len,1) cycles.
- Gap of 0 is promoted to 1 so consecutive runs remain separable.
REQ-019 done SHALL assert in the final GAP cycle. The FSM SHALL then return to IDLE, with req_ready high in the following cycle.
REQ-020 run_cnt SHALL increment by 1 on the RUN→GAP transition only. A run_len==0 request SHALL NOT increment it.
REQ-021 x, done, busy and req_ready SHALL be registered or decoded from registered state only, with no combinational path from req_valid.
REQ-022 Length counters SHALL be LEN_W-bit down-counters with no wrap. Maximum run_len = 2^LEN_W-1 cycles.

Reset
REQ-023 reset SHALL have priority over every other input on any edge, including mid-RUN or mid-GAP.
REQ-024 After reset the outputs SHALL be:
- state=IDLE, x=0, busy=0, done=0, req_ready=1, run_cnt=0;
- latched lengths cleared.
REQ-025 A request presented in the same cycle as reset SHALL be dropped.

Configuration
REQ-026 Macro SEQ_GEN_REPEAT_EN, when defined, SHALL add input port rep_en (1 bit).
- When rep_en is high in the final GAP cycle, the FSM SHALL re-enter RUN with the latched lengths instead of IDLE.
- done SHALL still pulse in that cycle.
REQ-027 With SEQ_GEN_REPEAT_EN undefined, the rep_en port SHALL be absent and the FSM SHALL always return to IDLE after GAP.

Structure
REQ-028 A shared package seq_gen_pkg SHALL hold:
- the state enum (IDLE, RUN, GAP);
- default LEN_W and CNT_W constants.
REQ-029 One sub-module, len_cnt, SHALL implement the loadable LEN_W down-counter with load, dec and zero outputs. It SHALL be instantiated once and reused for both RUN and GAP phases.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Reset, then run_len=3, gap_len=2 at edge N -> x=1 on cycles N+1..N+3, x=0 on N+4..N+5, done at N+5, run_cnt=1, req_ready=1 at N+6.
- run_len=0, gap_len=0 -> x stays 0, one GAP cycle with done=1, run_cnt unchanged.
- req_valid held high continuously with run_len=1, gap_len=1 -> pattern 1,0,idle repeating every 3 cycles; the detector's y pulses once per run.
- reset asserted on the 2nd cycle of run_len=5 -> x=0 and req_ready=1 at the next edge, run_cnt=0.
- 256 requests with run_len=1 -> run_cnt wraps to 0.
- With SEQ_GEN_REPEAT_EN defined, rep_en=1, run_len=2, gap_len=1 -> x=1,1,0 repeating, done each period; rep_en dropped -> returns to IDLE after the current gap.
